// File: rtl/vc_input_buffer.sv
// vc_input_buffer: per-input-port virtual-channel flit buffer.
// One FIFO per VC; each VC's head flit is presented to the crossbar. A switch
// grant pops the chosen VC, and one credit is returned upstream per popped flit.
// A small per-VC FSM tracks packet framing and flags protocol errors.
// Optional feature: define VCBUF_BYPASS_EN to let a flit arriving at an empty
// VC appear on that VC's outputs combinationally, and be consumed in the same cycle.
module vc_input_buffer #(
  parameter int unsigned PORT_BANDWIDTH = 32,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned NUM_VCS        = 4,
  parameter int unsigned VC_ID_BITS     = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  input  logic [VC_ID_BITS-1:0]                    in_vc,
  input  logic [PORT_BANDWIDTH-1:0]                in_flit,
  input  logic                                     pop,
  input  logic [VC_ID_BITS-1:0]                    pop_vc,
  output logic [NUM_VCS-1:0][PORT_BANDWIDTH-1:0]   vc_flit,
  output logic [NUM_VCS-1:0]                       vc_valid,
  output logic [NUM_VCS-1:0]                       vc_head,
  output logic [NUM_VCS-1:0]                       vc_active,
  output logic                                     credit_valid,
  output logic [VC_ID_BITS-1:0]                    credit_vc,
  output logic [2:0]                               err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_e;

  logic [PORT_BANDWIDTH-1:0] mem_q [NUM_VCS][DEPTH];
  logic [PW-1:0]             wptr_q [NUM_VCS];
  logic [PW-1:0]             wptr_d [NUM_VCS];
  logic [PW-1:0]             rptr_q [NUM_VCS];
  logic [PW-1:0]             rptr_d [NUM_VCS];
  logic [CW-1:0]             cnt_q  [NUM_VCS];
  logic [CW-1:0]             cnt_d  [NUM_VCS];
  vc_state_e                 state_q [NUM_VCS];
  vc_state_e                 state_d [NUM_VCS];
  logic                      credit_valid_q, credit_valid_d;
  logic [VC_ID_BITS-1:0]     credit_vc_q, credit_vc_d;
  logic [2:0]                err_q, err_d;

  logic [NUM_VCS-1:0]        empty, full, wr_req, pop_req;
  logic [NUM_VCS-1:0]        pop_mem, pop_ok, wr_store, bypass;
  logic [PORT_BANDWIDTH-1:0] head_flit [NUM_VCS];
  flit_type_e                pop_type  [NUM_VCS];

  // Per-VC request decode, FIFO status and head-flit presentation.
  always_comb begin
    vc_flit  = '0;
    vc_valid = '0;
    vc_head  = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      empty[v]     = (cnt_q[v] == '0);
      full[v]      = (cnt_q[v] == CW'(DEPTH));
      wr_req[v]    = in_valid && (in_vc == VC_ID_BITS'(v));
      pop_req[v]   = pop && (pop_vc == VC_ID_BITS'(v));
      head_flit[v] = mem_q[v][rptr_q[v]];
`ifdef VCBUF_BYPASS_EN
      bypass[v]    = wr_req[v] && empty[v];
`else
      bypass[v]    = 1'b0;
`endif
      pop_mem[v]   = pop_req[v] && !empty[v];
      pop_ok[v]    = pop_mem[v] || (pop_req[v] && bypass[v]);
      // A bypassed flit that is popped in the same cycle is never stored;
      // a pop from a full FIFO frees the slot for a same-cycle write.
      wr_store[v]  = wr_req[v] && !(pop_req[v] && bypass[v]) && (!full[v] || pop_mem[v]);
      pop_type[v]  = flit_type_e'(empty[v] ? in_flit[PORT_BANDWIDTH-1 -: 2]
                                           : head_flit[v][PORT_BANDWIDTH-1 -: 2]);
      vc_valid[v]  = !empty[v] || bypass[v];
      if (!empty[v]) begin
        vc_flit[v] = head_flit[v];
        vc_head[v] = head_flit[v][PORT_BANDWIDTH-2];
      end else if (bypass[v]) begin
        vc_flit[v] = in_flit;
        vc_head[v] = in_flit[PORT_BANDWIDTH-2];
      end
    end
  end

  // Next state: pointers, occupancy, framing FSM, credit and sticky errors.
  always_comb begin
    wptr_d         = wptr_q;
    rptr_d         = rptr_q;
    cnt_d          = cnt_q;
    state_d        = state_q;
    err_d          = err_q;
    credit_valid_d = 1'b0;
    credit_vc_d    = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (wr_store[v]) wptr_d[v] = wptr_q[v] + 1'b1;
      if (pop_mem[v])  rptr_d[v] = rptr_q[v] + 1'b1;
      cnt_d[v] = cnt_q[v] + CW'(wr_store[v]) - CW'(pop_mem[v]);
      if (pop_req[v] && !pop_ok[v]) err_d[1] = 1'b1;
      if (wr_req[v] && !wr_store[v] && !(pop_req[v] && bypass[v])) err_d[0] = 1'b1;
      if (pop_ok[v]) begin
        credit_valid_d = 1'b1;
        credit_vc_d    = pop_vc;
        unique case (pop_type[v])
          FT_HEAD: begin
            if (state_q[v] == VC_ACTIVE) err_d[2] = 1'b1;
            state_d[v] = VC_ACTIVE;
          end
          FT_HEADTAIL: begin
            if (state_q[v] == VC_ACTIVE) err_d[2] = 1'b1;
            state_d[v] = VC_IDLE;
          end
          FT_TAIL: begin
            if (state_q[v] == VC_IDLE) err_d[2] = 1'b1;
            state_d[v] = VC_IDLE;
          end
          FT_BODY: begin
            if (state_q[v] == VC_IDLE) err_d[2] = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        wptr_q[v]  <= '0;
        rptr_q[v]  <= '0;
        cnt_q[v]   <= '0;
        state_q[v] <= VC_IDLE;
      end
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
      err_q          <= '0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      credit_valid_q <= credit_valid_d;
      credit_vc_q    <= credit_vc_d;
      err_q          <= err_d;
    end
  end

  // Flit storage; contents are only observed through non-empty FIFOs, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      if (wr_store[v]) mem_q[v][wptr_q[v]] <= in_flit;
    end
  end

  // Framing state exported per VC.
  always_comb begin
    vc_active = '0;
    for (int unsigned v = 0; v < NUM_VCS; v++) begin
      vc_active[v] = (state_q[v] == VC_ACTIVE);
    end
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;
  assign err          = err_q;

endmodule

// File: tb/tb_vc_input_buffer.sv
// Self-checking bench for vc_input_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_vc_input_buffer;

  localparam int unsigned PB    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NV    = 4;
  localparam int unsigned VB    = 2;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [VB-1:0]            in_vc;
  logic [PB-1:0]            in_flit;
  logic                     pop;
  logic [VB-1:0]            pop_vc;
  logic [NV-1:0][PB-1:0]    vc_flit;
  logic [NV-1:0]            vc_valid;
  logic [NV-1:0]            vc_head;
  logic [NV-1:0]            vc_active;
  logic                     credit_valid;
  logic [VB-1:0]            credit_vc;
  logic [2:0]               err;

  int n_checks = 0;
  int n_fail   = 0;

  vc_input_buffer #(
    .PORT_BANDWIDTH (PB),
    .DEPTH          (DEPTH),
    .NUM_VCS        (NV),
    .VC_ID_BITS     (VB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_vc        (in_vc),
    .in_flit      (in_flit),
    .pop          (pop),
    .pop_vc       (pop_vc),
    .vc_flit      (vc_flit),
    .vc_valid     (vc_valid),
    .vc_head      (vc_head),
    .vc_active    (vc_active),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per VC, a packet-open flag per VC, sticky errors.
  logic [PB-1:0] mq [NV][$];
  logic [NV-1:0] m_open;
  logic [2:0]    m_err;
  logic          m_cv;
  logic [VB-1:0] m_cvc;

  function automatic logic [PB-1:0] mkf(input logic [1:0] t, input int unsigned pl);
    return {t, (PB-2)'(pl)};
  endfunction

  function automatic logic [PB-1:0] exp_flit(input int v);
    if (mq[v].size() > 0) return mq[v][0];
    return '0;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) mq[v].delete();
    m_open = '0;
    m_err  = '0;
    m_cv   = 1'b0;
    m_cvc  = '0;
  endtask

  task automatic model_step(input logic iv, input logic [VB-1:0] ivc, input logic [PB-1:0] f,
                            input logic p, input logic [VB-1:0] pvc);
    logic          ok;
    logic          consumed;
    logic [PB-1:0] pf;
    logic [1:0]    t;
    ok = 1'b0;
    consumed = 1'b0;
    pf = '0;
    if (p) begin
      if (mq[pvc].size() > 0) begin
        pf = mq[pvc].pop_front();
        ok = 1'b1;
      end
`ifdef VCBUF_BYPASS_EN
      else if (iv && ivc == pvc) begin
        pf = f;
        ok = 1'b1;
        consumed = 1'b1;
      end
`endif
      else m_err[1] = 1'b1;
    end
    if (ok) begin
      t = pf[PB-1 -: 2];
      if (!m_open[pvc]) begin
        if (t == T_HEAD) m_open[pvc] = 1'b1;
        else if (t == T_BODY || t == T_TAIL) m_err[2] = 1'b1;
      end else begin
        if (t == T_TAIL) m_open[pvc] = 1'b0;
        else if (t == T_HEAD) m_err[2] = 1'b1;
        else if (t == T_HT) begin m_err[2] = 1'b1; m_open[pvc] = 1'b0; end
      end
    end
    m_cv  = ok;
    m_cvc = ok ? pvc : '0;
    if (iv && !consumed) begin
      if (mq[ivc].size() < DEPTH) mq[ivc].push_back(f);
      else m_err[0] = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge with inputs idle.
  task automatic cyc(input logic iv, input logic [VB-1:0] ivc, input logic [PB-1:0] f,
                     input logic p, input logic [VB-1:0] pvc);
    in_valid = iv;
    in_vc    = ivc;
    in_flit  = f;
    pop      = p;
    pop_vc   = pvc;
    model_step(iv, ivc, f, p, pvc);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    pop      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    cyc(1'b1, 2'd1, mkf(T_HEAD, 5), 1'b0, 2'd0);
    cyc(1'b1, 2'd3, mkf(T_HT, 6), 1'b1, 2'd1);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (vc_valid !== '0) begin n_fail++; $display("FAIL rst_async_valid got %b exp 0", vc_valid); end
    n_checks++; if (vc_flit !== '0) begin n_fail++; $display("FAIL rst_async_flit got %h exp 0", vc_flit); end
    n_checks++; if (vc_active !== '0 || vc_head !== '0) begin n_fail++; $display("FAIL rst_async_state got act %b head %b exp 0", vc_active, vc_head); end
    n_checks++; if (credit_valid !== 1'b0 || credit_vc !== '0 || err !== '0) begin n_fail++; $display("FAIL rst_async_cred got cv %b cvc %0d err %b exp 0", credit_valid, credit_vc, err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, 2'd0, '0, 1'b0, 2'd0);
    n_checks++; if (vc_valid !== '0 || err !== '0) begin n_fail++; $display("FAIL rst_release got valid %b err %b exp 0", vc_valid, err); end
  endtask

  task automatic test_packet();
    logic [1:0] types [3];
    types[0] = T_HEAD; types[1] = T_BODY; types[2] = T_TAIL;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd1, mkf(types[i], 100 + i), 1'b0, 2'd0);
    n_checks++; if (vc_flit[1] !== mkf(T_HEAD, 100) || vc_head[1] !== 1'b1) begin n_fail++; $display("FAIL pkt_head got %h/%b exp %h/1", vc_flit[1], vc_head[1], mkf(T_HEAD, 100)); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd0, '0, 1'b1, 2'd1);
      n_checks++; if (vc_active[1] !== (i < 2)) begin n_fail++; $display("FAIL pkt_active[%0d] got %b exp %b", i, vc_active[1], (i < 2)); end
      n_checks++; if (credit_valid !== 1'b1 || credit_vc !== 2'd1) begin n_fail++; $display("FAIL pkt_credit[%0d] got %b/%0d exp 1/1", i, credit_valid, credit_vc); end
    end
    cyc(1'b0, 2'd0, '0, 1'b0, 2'd0);
    n_checks++; if (credit_valid !== 1'b0 || vc_valid !== '0 || err !== '0) begin n_fail++; $display("FAIL pkt_end got cv %b valid %b err %b exp 0", credit_valid, vc_valid, err); end
  endtask

  task automatic test_overflow();
    logic [1:0] types [5];
    types[0] = T_HEAD; types[1] = T_BODY; types[2] = T_BODY; types[3] = T_TAIL; types[4] = T_HT;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 2'd0, mkf(types[i], 1 + i), 1'b0, 2'd0);
      n_checks++; if (err !== ((i == 4) ? 3'b001 : 3'b000)) begin n_fail++; $display("FAIL ovf_err[%0d] got %b exp %b", i, err, (i == 4) ? 3'b001 : 3'b000); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (vc_flit[0] !== mkf(types[i], 1 + i)) begin n_fail++; $display("FAIL ovf_order[%0d] got %h exp %h", i, vc_flit[0], mkf(types[i], 1 + i)); end
      cyc(1'b0, 2'd0, '0, 1'b1, 2'd0);
    end
    n_checks++; if (vc_valid[0] !== 1'b0 || err !== 3'b001) begin n_fail++; $display("FAIL ovf_drain got valid %b err %b exp 0/001", vc_valid[0], err); end
  endtask

  task automatic test_full_wr_pop();
    int unsigned exp_pl;
    do_reset();
    cyc(1'b1, 2'd0, mkf(T_HEAD, 10), 1'b0, 2'd0);
    for (int i = 1; i < 4; i++) cyc(1'b1, 2'd0, mkf(T_BODY, 10 + i), 1'b0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 2'd0, mkf(T_BODY, 20 + k), 1'b1, 2'd0);
      exp_pl = (k < 3) ? 11 + k : 17 + k;
      n_checks++; if (vc_flit[0][PB-3:0] !== (PB-2)'(exp_pl) || vc_valid[0] !== 1'b1) begin n_fail++; $display("FAIL full_wp_head[%0d] got %0d exp %0d", k, vc_flit[0][PB-3:0], exp_pl); end
      n_checks++; if (err !== 3'b000) begin n_fail++; $display("FAIL full_wp_err[%0d] got %b exp 000", k, err); end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (vc_flit[0] !== mkf(T_BODY, 21 + i)) begin n_fail++; $display("FAIL full_wp_drain[%0d] got %h exp %h", i, vc_flit[0], mkf(T_BODY, 21 + i)); end
      cyc(1'b0, 2'd0, '0, 1'b1, 2'd0);
    end
    n_checks++; if (vc_valid[0] !== 1'b0) begin n_fail++; $display("FAIL full_wp_empty got %b exp 0", vc_valid[0]); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1'b0, 2'd0, '0, 1'b1, 2'd2);
    n_checks++; if (err !== 3'b010 || credit_valid !== 1'b0) begin n_fail++; $display("FAIL udf_pop got err %b cv %b exp 010/0", err, credit_valid); end
    do_reset();
    cyc(1'b1, 2'd2, mkf(T_HT, 77), 1'b1, 2'd2);
`ifdef VCBUF_BYPASS_EN
    n_checks++; if (err !== 3'b000 || credit_valid !== 1'b1 || credit_vc !== 2'd2 || vc_valid[2] !== 1'b0) begin n_fail++; $display("FAIL udf_bypass got err %b cv %b cvc %0d valid %b exp 000/1/2/0", err, credit_valid, credit_vc, vc_valid[2]); end
`else
    n_checks++; if (err !== 3'b010 || credit_valid !== 1'b0 || vc_flit[2] !== mkf(T_HT, 77)) begin n_fail++; $display("FAIL udf_wr_pop got err %b cv %b flit %h exp 010/0/%h", err, credit_valid, vc_flit[2], mkf(T_HT, 77)); end
`endif
  endtask

  task automatic test_proto();
    do_reset();
    cyc(1'b1, 2'd0, mkf(T_HT, 30), 1'b0, 2'd0);
    cyc(1'b1, 2'd1, mkf(T_HEAD, 40), 1'b0, 2'd0);
    cyc(1'b1, 2'd1, mkf(T_BODY, 41), 1'b0, 2'd0);
    cyc(1'b1, 2'd0, mkf(T_BODY, 31), 1'b0, 2'd0);
    cyc(1'b1, 2'd1, mkf(T_TAIL, 42), 1'b1, 2'd1);
    n_checks++; if (vc_active[1] !== 1'b1 || vc_head[0] !== 1'b1) begin n_fail++; $display("FAIL proto_vc1_open got act %b head0 %b exp 1/1", vc_active[1], vc_head[0]); end
    cyc(1'b0, 2'd0, '0, 1'b1, 2'd0);
    n_checks++; if (err !== 3'b000 || vc_active[0] !== 1'b0) begin n_fail++; $display("FAIL proto_ht got err %b act0 %b exp 000/0", err, vc_active[0]); end
    cyc(1'b0, 2'd0, '0, 1'b1, 2'd0);
    n_checks++; if (err !== 3'b100 || vc_active !== 4'b0010) begin n_fail++; $display("FAIL proto_body_idle got err %b act %b exp 100/0010", err, vc_active); end
    cyc(1'b0, 2'd0, '0, 1'b1, 2'd1);
    cyc(1'b0, 2'd0, '0, 1'b1, 2'd1);
    n_checks++; if (err !== 3'b100 || vc_active !== 4'b0000) begin n_fail++; $display("FAIL proto_vc1_close got err %b act %b exp 100/0000", err, vc_active); end
  endtask

  task automatic test_random();
    logic [PB-1:0] ef;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 2) == 0, VB'($urandom), {2'($urandom), (PB-2)'($urandom)},
          ($urandom % 5) < 3, VB'($urandom));
      for (int v = 0; v < NV; v++) begin
        ef = exp_flit(v);
        n_checks++; if (vc_flit[v] !== ef || vc_valid[v] !== (mq[v].size() > 0)) begin n_fail++; $display("FAIL rnd_flit[%0d] vc%0d got %h/%b exp %h/%b", n, v, vc_flit[v], vc_valid[v], ef, (mq[v].size() > 0)); end
        n_checks++; if (vc_head[v] !== (mq[v].size() > 0 && ef[PB-2]) || vc_active[v] !== m_open[v]) begin n_fail++; $display("FAIL rnd_state[%0d] vc%0d got head %b act %b exp act %b", n, v, vc_head[v], vc_active[v], m_open[v]); end
      end
      n_checks++; if (credit_valid !== m_cv || (m_cv && credit_vc !== m_cvc)) begin n_fail++; $display("FAIL rnd_credit[%0d] got %b/%0d exp %b/%0d", n, credit_valid, credit_vc, m_cv, m_cvc); end
      n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d] got %b exp %b", n, err, m_err); end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_vc    = '0;
    in_flit  = '0;
    pop      = 1'b0;
    pop_vc   = '0;
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_packet();
    test_overflow();
    test_full_wr_pop();
    test_underflow();
    test_proto();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
